// File: rtl/ball_steer_pkg.sv
// Shared direction codes, FSM encoding, playfield bounds and bounce helpers for ball_steer.
// Coordinates are quarter-pixels. Directions form a 16-point clockwise compass with 0 = up.
package ball_steer_pkg;

   typedef logic [3:0] dir_t;
   typedef logic [1:0] state_t;

   localparam dir_t DIR_UP    = 4'd0;
   localparam dir_t DIR_RIGHT = 4'd4;
   localparam dir_t DIR_DOWN  = 4'd8;
   localparam dir_t DIR_LEFT  = 4'd12;

   // Serve headings: after the right player scores the ball leaves down-right, otherwise down-left.
   localparam dir_t DIR_SERVE_AFTER_R = DIR_RIGHT + 4'd1;
   localparam dir_t DIR_SERVE_AFTER_L = DIR_LEFT - 4'd1;

   localparam state_t ST_SERVE  = 2'd0;
   localparam state_t ST_PLAY   = 2'd1;
   localparam state_t ST_SCORED = 2'd2;

   localparam int QPX_SCALE   = 4;
   localparam int PF_Y_MIN    = 10  * QPX_SCALE;
   localparam int PF_Y_MAX    = 470 * QPX_SCALE;
   localparam int PF_LEFT_X   = 20  * QPX_SCALE;
   localparam int PF_RIGHT_X  = 620 * QPX_SCALE;
   localparam int PF_PADDLE_H = 60  * QPX_SCALE;

   function automatic logic is_up(input dir_t d);
      return (d >= 4'd13) || (d <= 4'd3);
   endfunction

   function automatic logic is_down(input dir_t d);
      return (d >= 4'd5) && (d <= 4'd11);
   endfunction

   function automatic logic is_right(input dir_t d);
      return (d >= 4'd1) && (d <= 4'd7);
   endfunction

   function automatic logic is_left(input dir_t d);
      return d >= 4'd9;
   endfunction

   // Mirror about the horizontal axis; the 4-bit wrap gives the mod-16 result.
   function automatic dir_t wall_flip(input dir_t d);
      return 4'd8 - d;
   endfunction

   function automatic logic [1:0] paddle_zone(input logic [12:0] off, input int band);
      logic [12:0] q;
      q = off / 13'(band);
      return (q > 13'd3) ? 2'd3 : q[1:0];
   endfunction

   function automatic dir_t left_bounce(input logic [1:0] zone);
      case (zone)
         2'd0:    return 4'd2;
         2'd1:    return 4'd3;
         2'd2:    return 4'd5;
         default: return 4'd6;
      endcase
   endfunction

   function automatic dir_t right_bounce(input logic [1:0] zone);
      case (zone)
         2'd0:    return 4'd14;
         2'd1:    return 4'd13;
         2'd2:    return 4'd11;
         default: return 4'd10;
      endcase
   endfunction

endpackage

// File: rtl/ball_steer_if.sv
// Bundle between ball_steer and its surroundings: game enable, ball/paddle positions in,
// direction/move/re-centre/score out. master is the steering controller side.
interface ball_steer_if;
   import ball_steer_pkg::*;

   logic        enable;
   logic [12:0] ball_x;
   logic [12:0] ball_y;
   logic [12:0] paddle_l_y;
   logic [12:0] paddle_r_y;
   dir_t        direction;
   logic        move;
   logic        ball_rst;
   logic        score_l;
   logic        score_r;

   modport master (
      input  enable, ball_x, ball_y, paddle_l_y, paddle_r_y,
      output direction, move, ball_rst, score_l, score_r
   );

   modport slave (
      output enable, ball_x, ball_y, paddle_l_y, paddle_r_y,
      input  direction, move, ball_rst, score_l, score_r
   );

endinterface

// File: rtl/ball_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter that holds while enable is low.
// tick is combinational and high in the last count of each period.
module ball_tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] tick_cnt;

   assign tick = enable && (tick_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_cnt <= '0;
      else if (enable)
         tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
   end

endmodule

// File: rtl/ball_steer.sv
// Drives ball_move: periodic move strobe plus direction, with wall/paddle bounces, miss scoring
// and a serve sequence (score pulse, then ball_rst, then SERVE_DELAY ticks of hold).
module ball_steer
   import ball_steer_pkg::*;
#(
   parameter int TICK_DIV       = 100000,
   parameter int SERVE_DELAY    = 64,
   parameter int PADDLE_H       = PF_PADDLE_H,
   parameter int LEFT_PADDLE_X  = PF_LEFT_X,
   parameter int RIGHT_PADDLE_X = PF_RIGHT_X,
   parameter int Y_MIN          = PF_Y_MIN,
   parameter int Y_MAX          = PF_Y_MAX
) (
   input  logic         clk,
   input  logic         rst,
   ball_steer_if.master bus
);

   localparam int SCW    = $clog2(SERVE_DELAY + 1);
   localparam int ZONE_H = PADDLE_H / 4;

   logic               tick;
   state_t             state;
   logic [SCW-1:0]     serve_cnt;
   logic               check_pend;
   dir_t               dir_q;
   dir_t               dir_nxt;
   dir_t               serve_dir;
   logic               move_q;
   logic               ball_rst_q;
   logic               score_l_q;
   logic               score_r_q;
   logic               at_left;
   logic               at_right;
   logic               hit_l;
   logic               hit_r;
   logic               miss_left;
   logic               miss_right;
   logic signed [13:0] off_l;
   logic signed [13:0] off_r;

   ball_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (bus.enable),
      .tick   (tick)
   );

   assign off_l = $signed({1'b0, bus.ball_y}) - $signed({1'b0, bus.paddle_l_y});
   assign off_r = $signed({1'b0, bus.ball_y}) - $signed({1'b0, bus.paddle_r_y});

   assign at_left  = is_left(dir_q)  && (bus.ball_x <= 13'(LEFT_PADDLE_X));
   assign at_right = is_right(dir_q) && (bus.ball_x >= 13'(RIGHT_PADDLE_X));
   assign hit_l    = !off_l[13] && (off_l <= 14'(PADDLE_H));
   assign hit_r    = !off_r[13] && (off_r <= 14'(PADDLE_H));

   // Paddle outcome first; the wall flip then sees the post-bounce heading. A miss suppresses the flip.
   always_comb begin
      dir_nxt    = dir_q;
      miss_left  = 1'b0;
      miss_right = 1'b0;
      if (at_left) begin
         if (hit_l) dir_nxt   = left_bounce(paddle_zone(off_l[12:0], ZONE_H));
         else       miss_left = 1'b1;
      end else if (at_right) begin
         if (hit_r) dir_nxt    = right_bounce(paddle_zone(off_r[12:0], ZONE_H));
         else       miss_right = 1'b1;
      end
      if (!miss_left && !miss_right &&
          (((bus.ball_y <= 13'(Y_MIN)) && is_up(dir_nxt)) ||
           ((bus.ball_y >= 13'(Y_MAX)) && is_down(dir_nxt))))
         dir_nxt = wall_flip(dir_nxt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_SERVE;
         serve_cnt  <= '0;
         check_pend <= 1'b0;
         dir_q      <= DIR_SERVE_AFTER_R;
         serve_dir  <= DIR_SERVE_AFTER_R;
         move_q     <= 1'b0;
         ball_rst_q <= 1'b0;
         score_l_q  <= 1'b0;
         score_r_q  <= 1'b0;
      end else begin
         move_q     <= tick && (state == ST_PLAY);
         check_pend <= move_q;
         ball_rst_q <= 1'b0;
         score_l_q  <= 1'b0;
         score_r_q  <= 1'b0;
         // A pending check completes even while the game is paused.
         if (check_pend) begin
            if (miss_left) begin
               score_r_q <= 1'b1;
               serve_dir <= DIR_SERVE_AFTER_R;
               state     <= ST_SCORED;
            end else if (miss_right) begin
               score_l_q <= 1'b1;
               serve_dir <= DIR_SERVE_AFTER_L;
               state     <= ST_SCORED;
            end else begin
               dir_q <= dir_nxt;
            end
         end else if (bus.enable) begin
            case (state)
               ST_SERVE: begin
                  if (tick) begin
                     if (serve_cnt == SCW'(SERVE_DELAY - 1)) begin
                        serve_cnt <= '0;
                        state     <= ST_PLAY;
                     end else begin
                        serve_cnt <= serve_cnt + SCW'(1);
                     end
                  end
               end
               ST_SCORED: begin
                  ball_rst_q <= 1'b1;
                  dir_q      <= serve_dir;
                  serve_cnt  <= '0;
                  state      <= ST_SERVE;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.direction = dir_q;
   assign bus.move      = move_q;
   assign bus.ball_rst  = ball_rst_q;
   assign bus.score_l   = score_l_q;
   assign bus.score_r   = score_r_q;

endmodule

// File: tb/tb_ball_steer.sv
// Randomized and directed bench for ball_steer against a behavioural bounce/score model.
module tb_ball_steer;

   localparam int TD   = 4;
   localparam int SD   = 2;
   localparam int PH   = 240;
   localparam int LX   = 80;
   localparam int RX   = 2480;
   localparam int YMIN = 40;
   localparam int YMAX = 1880;
   localparam int SERVE_GAP = (SD + 1) * TD;

   logic clk = 1'b0;
   logic rst;
   int   nchk = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   last_move = 0;
   int   exp_gap = 0;
   int   mdir = 5;

   ball_steer_if ifc ();

   ball_steer #(
      .TICK_DIV(TD), .SERVE_DELAY(SD), .PADDLE_H(PH), .LEFT_PADDLE_X(LX),
      .RIGHT_PADDLE_X(RX), .Y_MIN(YMIN), .Y_MAX(YMAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Headings on a 16-point clock face; the paddle zone picks a new heading, walls mirror vertically.
   function automatic void model(input int d, input int bx, input int by, input int pl, input int pr,
                                 output int nd, output int ms);
      int off, z;
      nd = d;
      ms = 0;
      if (d >= 9 && bx <= LX) begin
         off = by - pl;
         if (off >= 0 && off <= PH) begin
            z  = off / (PH / 4);
            if (z > 3) z = 3;
            nd = (z == 0) ? 2 : (z == 1) ? 3 : (z == 2) ? 5 : 6;
         end else ms = 1;
      end else if (d >= 1 && d <= 7 && bx >= RX) begin
         off = by - pr;
         if (off >= 0 && off <= PH) begin
            z  = off / (PH / 4);
            if (z > 3) z = 3;
            nd = (z == 0) ? 14 : (z == 1) ? 13 : (z == 2) ? 11 : 10;
         end else ms = 2;
      end
      if (ms == 0) begin
         if ((by <= YMIN && (nd >= 13 || nd <= 3)) || (by >= YMAX && nd >= 5 && nd <= 11))
            nd = (24 - nd) % 16;
      end
   endfunction

   // Wait for the next move, act as ball_move by presenting the new position, then check the outcome.
   task automatic step(input int bx, input int by, input int pl, input int pr);
      int nd, ms, gap, sdir, fdir;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ifc.move === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      nchk++;
      if (!found) begin
         nerr++;
         $display("FAIL move_timeout: move stayed low for 200 clocks, wanted one after %0d", exp_gap);
         return;
      end
      gap = cyc - last_move;
      last_move = cyc;
      nchk++;
      if (gap != exp_gap) begin
         nerr++;
         $display("FAIL move_gap: got %0d clocks between moves, expected %0d", gap, exp_gap);
      end
      ifc.ball_x     = 13'(bx);
      ifc.ball_y     = 13'(by);
      ifc.paddle_l_y = 13'(pl);
      ifc.paddle_r_y = 13'(pr);
      model(mdir, bx, by, pl, pr, nd, ms);
      sdir = (ms == 1) ? 5 : 11;
      fdir = (ms == 0) ? nd : sdir;
      @(negedge clk);
      nchk++;
      if ({ifc.move, ifc.score_r, ifc.score_l, ifc.ball_rst} !== 4'b0000) begin
         nerr++;
         $display("FAIL check_cycle: move/score_r/score_l/ball_rst=%b expected 0000",
                  {ifc.move, ifc.score_r, ifc.score_l, ifc.ball_rst});
      end
      @(negedge clk);
      nchk++;
      if (ifc.direction !== 4'((ms == 0) ? nd : mdir)) begin
         nerr++;
         $display("FAIL dir_after_check: dir %0d at=(%0d,%0d) pl=%0d pr=%0d got %0d expected %0d",
                  mdir, bx, by, pl, pr, ifc.direction, (ms == 0) ? nd : mdir);
      end
      nchk++;
      if ({ifc.score_r, ifc.score_l} !== {ms == 1, ms == 2}) begin
         nerr++;
         $display("FAIL score_pulse: score_r/score_l=%b expected %b", {ifc.score_r, ifc.score_l},
                  {ms == 1, ms == 2});
      end
      @(negedge clk);
      nchk++;
      if ({ifc.ball_rst, ifc.score_r, ifc.score_l} !== {ms != 0, 2'b00}) begin
         nerr++;
         $display("FAIL ball_rst_follow: ball_rst/score_r/score_l=%b expected %b",
                  {ifc.ball_rst, ifc.score_r, ifc.score_l}, {ms != 0, 2'b00});
      end
      nchk++;
      if (ifc.direction !== 4'(fdir)) begin
         nerr++;
         $display("FAIL dir_settled: got %0d expected %0d", ifc.direction, fdir);
      end
      if (ms != 0) begin
         @(negedge clk);
         nchk++;
         if ({ifc.ball_rst, ifc.move} !== 2'b00) begin
            nerr++;
            $display("FAIL ball_rst_width: ball_rst/move=%b expected 00", {ifc.ball_rst, ifc.move});
         end
      end
      mdir    = fdir;
      exp_gap = (ms != 0) ? SERVE_GAP : TD;
   endtask

   task automatic test_reset();
      bit bad;
      rst = 1'b1;
      ifc.enable = 1'b0;
      ifc.ball_x = 13'd1200;
      ifc.ball_y = 13'd1000;
      ifc.paddle_l_y = 13'd0;
      ifc.paddle_r_y = 13'd0;
      @(negedge clk);
      nchk++;
      if ({ifc.direction, ifc.move, ifc.ball_rst, ifc.score_l, ifc.score_r} !== 8'b0101_0000) begin
         nerr++;
         $display("FAIL reset_outputs: dir=%0d move/ball_rst/score_l/score_r=%b expected dir=5 0000",
                  ifc.direction, {ifc.move, ifc.ball_rst, ifc.score_l, ifc.score_r});
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ifc.move !== 1'b0 || ifc.direction !== 4'd5) bad = 1'b1;
      end
      nchk++;
      if (bad) begin
         nerr++;
         $display("FAIL disabled_idle: move or direction changed with enable=0 (got bad=%0d, expected 0)", bad);
      end
   endtask

   task automatic test_serve();
      ifc.enable = 1'b1;
      last_move = cyc;
      exp_gap = SERVE_GAP;
      mdir = 5;
      repeat (3) step(1200, 1000, 0, 0);
   endtask

   task automatic test_bounces();
      int tbl [13][4] = '{
         '{1200, 1880, 0, 0},   '{1200, 40, 0, 0},     '{2480, 520, 0, 400},
         '{80, 830, 800, 0},    '{2480, 400, 0, 400},  '{80, 1040, 800, 0},
         '{1200, 1880, 0, 0},   '{1200, 40, 0, 0},     '{2480, 640, 0, 400},
         '{80, 40, 0, 0},       '{2480, 1880, 0, 400}, '{80, 1200, 800, 0},
         '{2480, 1000, 0, 1100}
      };
      for (int k = 0; k < 13; k++) step(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3]);
   endtask

   task automatic test_async_reset();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ifc.move === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      nchk++;
      if (!found) begin
         nerr++;
         $display("FAIL async_move_wait: no move before async reset (found=%0d, expected 1)", found);
      end
      #2 rst = 1'b1;
      #1;
      nchk++;
      if ({ifc.direction, ifc.move, ifc.ball_rst, ifc.score_l, ifc.score_r} !== 8'b0101_0000) begin
         nerr++;
         $display("FAIL async_reset: dir=%0d move/ball_rst/score_l/score_r=%b expected dir=5 0000",
                  ifc.direction, {ifc.move, ifc.ball_rst, ifc.score_l, ifc.score_r});
      end
      @(negedge clk);
      rst = 1'b0;
      mdir = 5;
      last_move = cyc;
      exp_gap = SERVE_GAP;
      repeat (2) step(1200, 1000, 0, 0);
   endtask

   task automatic test_enable_freeze();
      bit bad;
      step(1200, 1000, 0, 0);
      ifc.enable = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ifc.move !== 1'b0) bad = 1'b1;
      end
      nchk++;
      if (bad) begin
         nerr++;
         $display("FAIL freeze_no_move: move seen while enable=0 (bad=%0d, expected 0)", bad);
      end
      ifc.enable = 1'b1;
      exp_gap = TD + 10;
      repeat (2) step(1200, 1000, 0, 0);
   endtask

   task automatic test_random(input int n);
      for (int k = 0; k < n; k++) begin
         int bx, by, pl, pr, p, r, sel;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: bx = LX;
            1: bx = LX + 1;
            2: bx = LX - 30;
            3: bx = RX;
            4: bx = RX - 1;
            5: bx = RX + 30;
            default: bx = 1200;
         endcase
         pl = int'($urandom_range(0, 1600));
         pr = int'($urandom_range(0, 1600));
         p  = (bx < 1200) ? pl : pr;
         r  = int'($urandom_range(0, 320));
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      by = YMIN - (r % 41);
         else if (sel == 1) by = YMAX + (r % 61);
         else               by = p + r - 40;
         if (by < 0) by = 0;
         step(bx, by, pl, pr);
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_bounces();
      test_async_reset();
      test_enable_freeze();
      test_random(80);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/ball_steer.md
Name: ball_steer

Overview:
- Upstream controller for ball_move. Generates the periodic `move` strobe and the 4-bit `direction` code that ball_move consumes.
- Reads back ball_move's x/y in quarter-pixel units and reflects the ball off the top and bottom walls and off both paddles.
- Detects misses and emits score pulses.
- Sequences the serve: it pulses a ball re-centre request, then waits a fixed number of ticks before play resumes.

Parameters:
- TICK_DIV, 100000: clocks per move strobe; minimum legal value 4.
- SERVE_DELAY, 64: move-tick periods to hold the ball after a serve re-centre.
- PADDLE_H, 240: paddle height in quarter-pixels; must be divisible by 4.
- LEFT_PADDLE_X, 80: left paddle face x; quarter-pixels.
- RIGHT_PADDLE_X, 2480: right paddle face x; quarter-pixels.
- Y_MIN, 40: top wall y; quarter-pixels.
- Y_MAX, 1880: bottom wall y; quarter-pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  game running; low freezes tick counter and FSM
- ball_x  in  13  ball x from ball_move, quarter-pixels
- ball_y  in  13  ball y from ball_move, quarter-pixels
- paddle_l_y  in  13  left paddle top edge, quarter-pixels
- paddle_r_y  in  13  right paddle top edge, quarter-pixels
- direction  out  4  direction code to ball_move (0=up, 4=right, 8=down, 12=left, clockwise)
- move  out  1  one-cycle move strobe to ball_move
- ball_rst  out  1  one-cycle re-centre request; top ORs it with rst into ball_move rst
- score_l  out  1  one-cycle pulse, left player scored
- score_r  out  1  one-cycle pulse, right player scored

Behaviour:
- Reset (async, rst=1), all outputs and state forced to:
  - direction=5, move=0, ball_rst=0, score_l=0, score_r=0
  - tick_cnt=0, state=SERVE, serve_cnt=0, check_pend=0
- Tick counter: counts 0..TICK_DIV-1 and wraps while enable=1; holds while enable=0.
  - tick = (tick_cnt==TICK_DIV-1) & enable.
- move = tick & (state==PLAY), registered, so it is high exactly one cycle.
- Collision check timing:
  - check_pend is set the cycle after move=1, because ball_move's new x/y is visible then.
  - The check runs while check_pend=1, then check_pend clears.
  - Any direction change is registered and applies from the next move.
- Direction decode:
  - up-going: {13,14,15,0,1,2,3}
  - down-going: {5..11}
  - right-going: {1..7}
  - left-going: {9..15}
- Vertical wall flip:
  - Trigger: (ball_y<=Y_MIN & up-going) or (ball_y>=Y_MAX & down-going).
  - Result: dir <= (8-dir) mod 16, e.g. 1->7, 15->9.
- Left paddle:
  - Trigger: left-going & ball_x<=LEFT_PADDLE_X.
  - off = ball_y - paddle_l_y, computed 14-bit signed.
  - Hit when 0<=off<=PADDLE_H. zone = off/(PADDLE_H/4), clamped to 3.
  - New dir by zone 0..3: 2, 3, 5, 6.
  - Otherwise miss: score_r pulse, go SCORED.
- Right paddle: mirror of the left paddle using paddle_r_y.
  - Trigger: right-going & ball_x>=RIGHT_PADDLE_X.
  - New dir by zone 0..3: 14, 13, 11, 10.
  - Otherwise miss: score_l pulse, go SCORED.
- Simultaneous paddle hit and wall: take the paddle result first, then apply the wall flip if that result still points into the wall. Top wall plus zone 0 left hit therefore gives 2 -> 6.
- Miss plus wall in the same check: the miss wins; no flip.
- FSM states:
  - SERVE: move suppressed. serve_cnt increments on each tick. When serve_cnt==SERVE_DELAY-1 on a tick, clear serve_cnt and go PLAY.
  - PLAY: move strobes and collision checks active.
  - SCORED: one cycle. Assert ball_rst=1 and set serve direction: 5 after score_r, 11 after score_l. Go SERVE. serve_cnt=0.
- enable=0 in any state: state, serve_cnt and direction are held. A check_pend already set still completes.
- Score pulse timing: score_* occurs in the check cycle; ball_rst follows one cycle later. Each is exactly one cycle wide.

Decomposition:
- Shared package holds:
  - direction code constants (DIR_UP=0, DIR_RIGHT=4, DIR_DOWN=8, DIR_LEFT=12)
  - FSM state encoding (SERVE, PLAY, SCORED)
  - playfield constants: wall and paddle bounds, quarter-pixel scale of 4
- One sub-module: ball_tick_gen, the TICK_DIV counter with enable, producing tick.

Test Plan:
- Reset, then enable=1 with TICK_DIV=4, SERVE_DELAY=2 -> direction=5; no move for 8 clocks; then move every 4th clock, each 1 cycle wide.
- PLAY, dir=1, ball_y=40 at the check cycle -> direction=7 before the next move; dir=15 at ball_y=40 -> 9; dir=6 at ball_y=1880 -> 2.
- dir=12, ball_x=80, paddle_l_y=800, ball_y=830 (off=30, zone 0) -> direction=2; ball_y=1040 (off=240, clamped zone 3) -> 6.
- dir=4, ball_x=2480, paddle_r_y=400, ball_y=520 (zone 2) -> direction=11.
- dir=11, ball_x=80, paddle_l_y=800, ball_y=1200 -> score_r=1 for 1 cycle, ball_rst=1 the next cycle, direction=5, move absent for SERVE_DELAY ticks.
- Assert rst asynchronously mid-PLAY between clock edges -> all outputs at reset values immediately; state=SERVE after release. enable=0 for 10 clocks mid-PLAY -> no move, tick_cnt frozen, resumes from the same count.
